// File: rtl/coeff_sequencer_if.sv
// coeff_sequencer_if
//   Bundles the symbol-input and coefficient-output handshakes of the
//   coefficient sequencer.
//   Symbol side  : sym_valid/sym_ready, sym_rs (run/size), sym_bits (VLI bits),
//                  comp_id (DC predictor select).
//   Coeff side   : coef_valid/coef_ready, coef_data (signed 12-bit),
//                  coef_idx (zigzag 0..63), coef_last (idx 63 present).
//   master : the environment (symbol producer / coefficient consumer).
//   slave  : the sequencer itself.
interface coeff_sequencer_if;
  logic        sym_valid;
  logic        sym_ready;
  logic [7:0]  sym_rs;
  logic [10:0] sym_bits;
  logic [1:0]  comp_id;
  logic        coef_valid;
  logic        coef_ready;
  logic [11:0] coef_data;
  logic [5:0]  coef_idx;
  logic        coef_last;

  modport master (
    output sym_valid, sym_rs, sym_bits, comp_id, coef_ready,
    input  sym_ready, coef_valid, coef_data, coef_idx, coef_last
  );

  modport slave (
    input  sym_valid, sym_rs, sym_bits, comp_id, coef_ready,
    output sym_ready, coef_valid, coef_data, coef_idx, coef_last
  );
endinterface

// File: rtl/coeff_sequencer.sv
// vli_decoder
//   Turns a JPEG VLI (size, right-aligned magnitude bits) into a signed
//   12-bit value. A leading 1 means a positive value equal to the bits; a
//   leading 0 means a negative value equal to bits - (2^size - 1).
//   size : 0..11 (size 0 decodes to 0)
//   bits : magnitude bits, only the low 'size' bits are used
//   value: signed 12-bit result
module vli_decoder (
  input  logic [3:0]  size,
  input  logic [10:0] bits,
  output logic [11:0] value
);
  logic [11:0] mask;
  logic [11:0] mag;
  logic        top;

  always_comb begin
    mask = (12'd1 << size) - 12'd1;
    mag  = {1'b0, bits} & mask;
    // Isolates bit size-1; with size 0 both mask and mag are 0, so value is 0.
    top   = |(mag & ~(mask >> 1));
    value = top ? mag : (mag - mask);
  end
endmodule

// coeff_sequencer
//   Expands decoded Huffman symbols of one 8x8 block into 64 zigzag-ordered
//   coefficients: DC prediction per component, AC run/size expansion, ZRL,
//   EOB zero tail, and overflow/format-error handling.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low
//   pred_clr : synchronous restart, zeroes all DC predictors
//   err      : sticky format error, cleared only by reset
//   bus      : symbol input / coefficient output handshakes (slave side)
module coeff_sequencer (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_clr,
  output logic             err,
  coeff_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_DC, S_AC, S_ZERO, S_OUT, S_TAIL} state_e;

  state_e      state_q, state_d;
  // Zeros still to emit after the one currently on the output.
  logic [3:0]  run_q, run_d;
  logic        has_pend_q, has_pend_d;
  logic [11:0] pend_q, pend_d;
  logic [11:0] pred_q [3];
  logic [11:0] pred_d [3];
  logic        err_q, err_d;
  logic        coef_valid_q, coef_valid_d;
  logic [11:0] coef_data_q, coef_data_d;
  logic [5:0]  coef_idx_q, coef_idx_d;

  logic        sym_ready;
  logic        sym_acc;
  logic        coef_hs;
  logic [3:0]  sym_size;
  logic [3:0]  run_len;
  logic        is_eob;
  logic        is_zrl;
  logic        size_bad;
  logic        comp_bad;
  logic [1:0]  comp_eff;
  logic [3:0]  vli_size;
  logic [11:0] vli_val;
  logic [11:0] dc_base;
  logic [11:0] dc_val;

  vli_decoder u_vli (
    .size  (vli_size),
    .bits  (bus.sym_bits),
    .value (vli_val)
  );

  // Symbol decode shared by the DC and AC paths; illegal size or component
  // is forced to 0 so the block still completes with 64 coefficients.
  always_comb begin
    sym_size = bus.sym_rs[3:0];
    run_len  = bus.sym_rs[7:4];
    is_eob   = (bus.sym_rs == 8'h00);
    is_zrl   = (bus.sym_rs == 8'hF0);
    size_bad = (state_q == S_DC) ? (sym_size > 4'd11) : (sym_size > 4'd10);
    comp_bad = (bus.comp_id == 2'd3);
    comp_eff = comp_bad ? 2'd0 : bus.comp_id;
    vli_size = size_bad ? 4'd0 : sym_size;
    sym_acc  = bus.sym_valid & sym_ready;
    coef_hs  = coef_valid_q & bus.coef_ready;
    case (comp_eff)
      2'd1:    dc_base = pred_q[1];
      2'd2:    dc_base = pred_q[2];
      default: dc_base = pred_q[0];
    endcase
    // A coincident restart makes this DC predict from zero.
    if (pred_clr) dc_base = 12'd0;
    dc_val = dc_base + vli_val;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_DC;
      run_q        <= '0;
      has_pend_q   <= 1'b0;
      pend_q       <= '0;
      for (int k = 0; k < 3; k++) pred_q[k] <= '0;
      err_q        <= 1'b0;
      coef_valid_q <= 1'b0;
      coef_data_q  <= '0;
      coef_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      has_pend_q   <= has_pend_d;
      pend_q       <= pend_d;
      for (int k = 0; k < 3; k++) pred_q[k] <= pred_d[k];
      err_q        <= err_d;
      coef_valid_q <= coef_valid_d;
      coef_data_q  <= coef_data_d;
      coef_idx_q   <= coef_idx_d;
    end
  end

  // Next-state logic. The output register always holds the coefficient
  // being presented; on a handshake the following one is loaded in the same
  // cycle so runs stream without bubbles. In S_AC, coef_idx_q still holds
  // the last emitted position, so the next position is coef_idx_q + 1.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    has_pend_d   = has_pend_q;
    pend_d       = pend_q;
    err_d        = err_q;
    coef_valid_d = coef_valid_q;
    coef_data_d  = coef_data_q;
    coef_idx_d   = coef_idx_q;
    for (int k = 0; k < 3; k++) begin
      pred_d[k] = pred_clr ? 12'd0 : pred_q[k];
      if (state_q == S_DC && sym_acc && comp_eff == 2'(k)) pred_d[k] = dc_val;
    end

    unique case (state_q)
      S_DC: begin
        if (sym_acc) begin
          if (size_bad || comp_bad) err_d = 1'b1;
          coef_valid_d = 1'b1;
          coef_data_d  = dc_val;
          coef_idx_d   = 6'd0;
          state_d      = S_OUT;
        end
      end
      S_AC: begin
        if (sym_acc) begin
          coef_valid_d = 1'b1;
          coef_idx_d   = coef_idx_q + 6'd1;
          coef_data_d  = 12'd0;
          if (is_eob) begin
            state_d = S_TAIL;
          end else if (is_zrl) begin
            run_d      = 4'd15;
            has_pend_d = 1'b0;
            state_d    = S_ZERO;
          end else begin
            if (size_bad) err_d = 1'b1;
            if (run_len != 4'd0) begin
              run_d      = run_len - 4'd1;
              has_pend_d = 1'b1;
              pend_d     = vli_val;
              state_d    = S_ZERO;
            end else begin
              coef_data_d = vli_val;
              state_d     = S_OUT;
            end
          end
        end
      end
      S_ZERO: begin
        if (coef_hs) begin
          if (coef_idx_q == 6'd63) begin
            // Block is full; anything still owed overflows and is dropped.
            if (run_q != 4'd0 || has_pend_q) err_d = 1'b1;
            has_pend_d   = 1'b0;
            run_d        = 4'd0;
            coef_valid_d = 1'b0;
            state_d      = S_DC;
          end else if (run_q != 4'd0) begin
            coef_idx_d  = coef_idx_q + 6'd1;
            coef_data_d = 12'd0;
            run_d       = run_q - 4'd1;
          end else if (has_pend_q) begin
            coef_idx_d  = coef_idx_q + 6'd1;
            coef_data_d = pend_q;
            has_pend_d  = 1'b0;
            state_d     = S_OUT;
          end else begin
            coef_valid_d = 1'b0;
            state_d      = S_AC;
          end
        end
      end
      S_OUT: begin
        if (coef_hs) begin
          coef_valid_d = 1'b0;
          state_d      = (coef_idx_q == 6'd63) ? S_DC : S_AC;
        end
      end
      S_TAIL: begin
        if (coef_hs) begin
          if (coef_idx_q == 6'd63) begin
            coef_valid_d = 1'b0;
            state_d      = S_DC;
          end else begin
            coef_idx_d  = coef_idx_q + 6'd1;
            coef_data_d = 12'd0;
          end
        end
      end
      default: state_d = S_DC;
    endcase
  end

  // Outputs. sym_ready is held low while reset is asserted so nothing is
  // accepted before release.
  always_comb begin
    sym_ready      = reset && (state_q == S_DC || state_q == S_AC);
    bus.sym_ready  = sym_ready;
    bus.coef_valid = coef_valid_q;
    bus.coef_data  = coef_data_q;
    bus.coef_idx   = coef_idx_q;
    bus.coef_last  = coef_valid_q && (coef_idx_q == 6'd63);
    err            = err_q;
  end

endmodule

// File: tb/tb_coeff_sequencer.sv
// tb_coeff_sequencer
//   Directed bench for coeff_sequencer: drives symbols through the master
//   side of the interface, records every coefficient handshake, and compares
//   each block against hand-computed expected contents.
module tb_coeff_sequencer;

  typedef struct {
    logic [11:0] data;
    logic [5:0]  idx;
    logic        last;
  } coef_t;

  logic        clk;
  logic        reset;
  logic        pred_clr;
  logic        err;
  int          checks;
  int          errors;
  coef_t       got[$];
  logic [11:0] expData [64];
  logic        toggleReady;
  logic        prevStall;
  logic [11:0] prevData;
  logic [5:0]  prevIdx;

  coeff_sequencer_if bus ();

  coeff_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .pred_clr (pred_clr),
    .err      (err),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one symbol at a falling edge and holds it until accepted.
  task automatic applyStimulus(input logic [7:0] rs, input logic [10:0] bits,
                               input logic [1:0] comp);
    int n;
    n = 0;
    bus.sym_valid = 1'b1;
    bus.sym_rs    = rs;
    bus.sym_bits  = bits;
    bus.comp_id   = comp;
    while (!bus.sym_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sym_accept", {31'd0, bus.sym_ready}, 32'd1);
    if (bus.sym_ready) @(negedge clk);
    bus.sym_valid = 1'b0;
  endtask

  // Waits for a full block, then compares it against expData.
  task automatic checkBlock(input string tag);
    int n;
    int dataErrs;
    int idxErrs;
    int lastErrs;
    n = 0;
    while (got.size() < 64 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput({tag, "_count"}, got.size(), 32'd64);
    dataErrs = 0;
    idxErrs  = 0;
    lastErrs = 0;
    for (int i = 0; i < 64 && i < got.size(); i++) begin
      if (got[i].data !== expData[i]) begin
        dataErrs++;
        $display("[TB] %s idx %0d data=%0h want=%0h", tag, i, got[i].data, expData[i]);
      end
      if (got[i].idx !== 6'(i)) idxErrs++;
      if (got[i].last !== (i == 63)) lastErrs++;
    end
    if (got.size() > 0) checkOutput({tag, "_idx0"}, {20'd0, got[0].data}, {20'd0, expData[0]});
    checkOutput({tag, "_data"}, dataErrs, 32'd0);
    checkOutput({tag, "_idx_seq"}, idxErrs, 32'd0);
    checkOutput({tag, "_last"}, lastErrs, 32'd0);
  endtask

  task automatic clearExpect();
    for (int i = 0; i < 64; i++) expData[i] = 12'd0;
    got.delete();
  endtask

  // Optional coef_ready toggling for stall tests.
  always @(negedge clk) begin
    if (toggleReady) bus.coef_ready = ~bus.coef_ready;
  end

  // Monitor: observes just after each falling edge, where inputs are
  // settled for the coming rising edge. Records handshakes, checks that a
  // stalled coefficient is held, and that no symbol is taken while one is
  // being presented.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      if (bus.coef_valid) checkOutput("sym_ready_low_while_emitting", {31'd0, bus.sym_ready}, 32'd0);
      if (prevStall) begin
        checkOutput("held_valid", {31'd0, bus.coef_valid}, 32'd1);
        checkOutput("held_data", {20'd0, bus.coef_data}, {20'd0, prevData});
        checkOutput("held_idx", {26'd0, bus.coef_idx}, {26'd0, prevIdx});
      end
      if (bus.coef_valid && bus.coef_ready)
        got.push_back('{data: bus.coef_data, idx: bus.coef_idx, last: bus.coef_last});
      prevStall = bus.coef_valid && !bus.coef_ready;
      prevData  = bus.coef_data;
      prevIdx   = bus.coef_idx;
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    checks         = 0;
    errors         = 0;
    toggleReady    = 1'b0;
    prevStall      = 1'b0;
    prevData       = '0;
    prevIdx        = '0;
    reset          = 1'b0;
    pred_clr       = 1'b0;
    bus.sym_valid  = 1'b0;
    bus.sym_rs     = 8'h00;
    bus.sym_bits   = 11'd0;
    bus.comp_id    = 2'd0;
    bus.coef_ready = 1'b1;
    clearExpect();

    // Reset state.
    #1;
    checkOutput("rst_coef_valid", {31'd0, bus.coef_valid}, 32'd0);
    checkOutput("rst_coef_idx", {26'd0, bus.coef_idx}, 32'd0);
    checkOutput("rst_coef_data", {20'd0, bus.coef_data}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_sym_ready", {31'd0, bus.sym_ready}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("release_sym_ready", {31'd0, bus.sym_ready}, 32'd1);

    // DC +7 on component 0, then EOB.
    $display("[TB] block: DC 7 + EOB");
    clearExpect();
    expData[0] = 12'd7;
    applyStimulus(8'h03, 11'b111, 2'd0);
    applyStimulus(8'h00, 11'd0, 2'd0);
    checkBlock("dc7");

    // DC diff -1 on predictor 7 gives 6.
    clearExpect();
    expData[0] = 12'd6;
    applyStimulus(8'h01, 11'd0, 2'd0);
    applyStimulus(8'h00, 11'd0, 2'd0);
    checkBlock("dc_pred");

    // Restart clears the predictor: diff -1 gives -1.
    pred_clr = 1'b1;
    @(negedge clk);
    pred_clr = 1'b0;
    clearExpect();
    expData[0] = 12'hFFF;
    applyStimulus(8'h01, 11'd0, 2'd0);
    applyStimulus(8'h00, 11'd0, 2'd0);
    checkBlock("pred_clr");

    // AC run 2 value +1 on component 1.
    clearExpect();
    expData[3] = 12'd1;
    applyStimulus(8'h00, 11'd0, 2'd1);
    applyStimulus(8'h21, 11'd1, 2'd1);
    applyStimulus(8'h00, 11'd0, 2'd1);
    checkBlock("ac_run2");
    checkOutput("err_clean", {31'd0, err}, 32'd0);

    // Three ZRLs then run 15: the value would land at 64 and is dropped.
    clearExpect();
    applyStimulus(8'h00, 11'd0, 2'd2);
    applyStimulus(8'hF0, 11'd0, 2'd0);
    applyStimulus(8'hF0, 11'd0, 2'd0);
    applyStimulus(8'hF0, 11'd0, 2'd0);
    applyStimulus(8'hF1, 11'd1, 2'd0);
    checkBlock("overflow");
    checkOutput("overflow_err", {31'd0, err}, 32'd1);

    // Next symbol is a DC on component 2 (predictor 0): +2.
    clearExpect();
    expData[0] = 12'd2;
    applyStimulus(8'h02, 11'b10, 2'd2);
    applyStimulus(8'h00, 11'd0, 2'd0);
    checkBlock("after_overflow");
    checkOutput("err_sticky", {31'd0, err}, 32'd1);

    // Stalls during a zero run: component 1 pred 0 + 1, then run 5 value -1.
    clearExpect();
    expData[0] = 12'd1;
    expData[6] = 12'hFFF;
    toggleReady = 1'b1;
    applyStimulus(8'h01, 11'd1, 2'd1);
    applyStimulus(8'h51, 11'd0, 2'd0);
    applyStimulus(8'h00, 11'd0, 2'd0);
    checkBlock("stall");
    toggleReady    = 1'b0;
    bus.coef_ready = 1'b1;
    @(negedge clk);

    // Reset in the middle of the zero tail abandons the block.
    clearExpect();
    applyStimulus(8'h02, 11'b11, 2'd0);
    applyStimulus(8'h00, 11'd0, 2'd0);
    bus.coef_ready = 1'b0;
    @(negedge clk);
    checkOutput("tail_valid", {31'd0, bus.coef_valid}, 32'd1);
    checkOutput("tail_idx", {26'd0, bus.coef_idx}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_coef_valid", {31'd0, bus.coef_valid}, 32'd0);
    checkOutput("midrst_coef_idx", {26'd0, bus.coef_idx}, 32'd0);
    checkOutput("midrst_err", {31'd0, err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.coef_ready = 1'b1;
    @(negedge clk);
    clearExpect();
    expData[0] = 12'h801;
    applyStimulus(8'h0B, 11'd0, 2'd0);
    applyStimulus(8'h00, 11'd0, 2'd0);
    checkBlock("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
